// File: rtl/ingress_pkt_arbiter.sv
// Packet-granular round-robin arbiter in front of the Ethernet parser: a granted port keeps the
// output until its last beat. Define INGRESS_ARB_TIMEOUT_EN for the idle-beat timeout/abort path.

module ingress_pkt_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_PORTS = 4,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int IDX_W = $clog2(DATA_WIDTH/8+1),
   localparam int PORT_W = $clog2(NUM_PORTS)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
   input  logic [NUM_PORTS*IDX_W-1:0]      s_idx,
   input  logic [NUM_PORTS-1:0]            s_valid,
   input  logic [NUM_PORTS-1:0]            s_last,
   output logic [NUM_PORTS-1:0]            s_ready,
   output logic [DATA_WIDTH-1:0]           m_tdata,
   output logic [IDX_W-1:0]                m_idx,
   output logic                            m_valid,
   output logic                            m_last,
   input  logic                            m_ready,
   output logic [PORT_W-1:0]               m_port,
   output logic                            m_abort,
   output logic                            busy
);

   if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1 || (DATA_WIDTH % 8) != 0) begin : g_param_check
      $error("ingress_pkt_arbiter: unsupported parameter set");
   end

   typedef enum logic [1:0] {
      IDLE,
      PASS
`ifdef INGRESS_ARB_TIMEOUT_EN
      , ABORT
`endif
   } state_t;

   localparam logic [PORT_W:0]   NUM_PORTS_X = (PORT_W+1)'(NUM_PORTS);
   localparam logic [PORT_W-1:0] LAST_PORT   = PORT_W'(NUM_PORTS-1);

   state_t              state_q, state_d;
   logic [PORT_W-1:0]   grant_q, grant_d;
   logic [PORT_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [PORT_W-1:0]   next_ptr;
   logic [PORT_W:0]     cand;
   logic [PORT_W-1:0]   pick;
   logic                pick_found;
   logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];
   logic [IDX_W-1:0]      port_idx  [NUM_PORTS];

`ifdef INGRESS_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES+1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

   always_comb begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         port_data[p] = s_tdata[p*DATA_WIDTH +: DATA_WIDTH];
         port_idx[p]  = s_idx[p*IDX_W +: IDX_W];
      end
   end

   // First requester at or above rr_ptr, wrapping; the sum is one bit wider so the wrap is exact.
   always_comb begin
      cand       = '0;
      pick       = '0;
      pick_found = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = {1'b0, rr_ptr_q} + (PORT_W+1)'(i);
         if (cand >= NUM_PORTS_X) begin
            cand = cand - NUM_PORTS_X;
         end
         if (!pick_found && s_valid[cand[PORT_W-1:0]]) begin
            pick       = cand[PORT_W-1:0];
            pick_found = 1'b1;
         end
      end
   end

   assign next_ptr = (grant_q == LAST_PORT) ? '0 : grant_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      s_ready  = '0;
      m_tdata  = '0;
      m_idx    = '0;
      m_valid  = 1'b0;
      m_last   = 1'b0;
      m_port   = '0;
      m_abort  = 1'b0;
      busy     = 1'b0;
`ifdef INGRESS_ARB_TIMEOUT_EN
      idle_cnt_d = idle_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_d = pick;
               state_d = PASS;
`ifdef INGRESS_ARB_TIMEOUT_EN
               idle_cnt_d = '0;
`endif
            end
         end
         PASS: begin
            busy             = 1'b1;
            m_port           = grant_q;
            m_valid          = s_valid[grant_q];
            m_tdata          = port_data[grant_q];
            m_idx            = port_idx[grant_q];
            m_last           = s_last[grant_q];
            s_ready[grant_q] = m_ready;
            if (s_valid[grant_q] && m_ready && s_last[grant_q]) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end
`ifdef INGRESS_ARB_TIMEOUT_EN
            // Only cycles where the granted source offers nothing count toward the abort.
            if (s_valid[grant_q]) begin
               idle_cnt_d = '0;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
               if (idle_cnt_d == CNT_LIMIT) begin
                  state_d = ABORT;
               end
            end
`endif
         end
`ifdef INGRESS_ARB_TIMEOUT_EN
         ABORT: begin
            busy    = 1'b1;
            m_port  = grant_q;
            m_valid = 1'b1;
            m_last  = 1'b1;
            m_abort = 1'b1;
            if (m_ready) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end
         end
`endif
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef INGRESS_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_ingress_pkt_arbiter.sv
// Self-checking bench for ingress_pkt_arbiter: packet-level reference model, per-port beat
// scoreboard, directed scenarios and a randomized phase. Timeout scenario needs INGRESS_ARB_TIMEOUT_EN.

module tb_ingress_pkt_arbiter;

   localparam int DW = 64;
   localparam int NP = 4;
   localparam int TO = 8;
   localparam int IW = 4;
   localparam int PW = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NP*DW-1:0]   s_tdata;
   logic [NP*IW-1:0]   s_idx;
   logic [NP-1:0]      s_valid;
   logic [NP-1:0]      s_last;
   logic [NP-1:0]      s_ready;
   logic [DW-1:0]      m_tdata;
   logic [IW-1:0]      m_idx;
   logic               m_valid;
   logic               m_last;
   logic               m_ready;
   logic [PW-1:0]      m_port;
   logic               m_abort;
   logic               busy;

   ingress_pkt_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_tdata(s_tdata), .s_idx(s_idx), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_tdata(m_tdata), .m_idx(m_idx), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .m_port(m_port), .m_abort(m_abort), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] idx;
      logic          last;
   } beat_t;

   beat_t       drv_q [NP][$];
   beat_t       exp_q [NP][$];
   int          stall_at [NP];
   int          sent_in_pkt [NP];
   int          gap_pct;
   bit          rand_ready;
   int          stall_ready;
   logic [NP-1:0] acc_s;
   int          total;
   int          bad;
   int          out_order [$];
   int          exp_order [$];

   // Reference model: who owns the output, where the next search starts, abort bookkeeping.
   int          mdl_owner;
   int          mdl_rr;
   int          mdl_idle;
   bit          mdl_abort;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   task automatic pushBeat(input int p, input beat_t bt);
      drv_q[p].push_back(bt);
      exp_q[p].push_back(bt);
   endtask

   task automatic pushPacket(input int p, input int nbeats, input logic [63:0] base);
      beat_t bt;
      for (int b = 0; b < nbeats; b++) begin
         bt.data = base + 64'(b);
         bt.idx  = IW'($urandom_range(8));
         bt.last = (b == nbeats-1);
         pushBeat(p, bt);
      end
   endtask

   // One clock: drive sources/m_ready after the edge, then return at the falling edge.
   task automatic applyStimulus();
      beat_t bt;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (acc_s[p] && drv_q[p].size() > 0) begin
            bt = drv_q[p].pop_front();
            if (bt.last) sent_in_pkt[p] = 0;
            else sent_in_pkt[p]++;
         end
         if (!(s_valid[p] && !acc_s[p])) begin
            if (drv_q[p].size() > 0 && sent_in_pkt[p] != stall_at[p] &&
                int'($urandom_range(99)) >= gap_pct) begin
               s_valid[p]            = 1'b1;
               s_tdata[p*DW +: DW]   = drv_q[p][0].data;
               s_idx[p*IW +: IW]     = drv_q[p][0].idx;
               s_last[p]             = drv_q[p][0].last;
            end else begin
               s_valid[p]            = 1'b0;
               s_tdata[p*DW +: DW]   = {$urandom, $urandom};
               s_idx[p*IW +: IW]     = IW'($urandom_range(8));
               s_last[p]             = 1'($urandom_range(1));
            end
         end
      end
      if (stall_ready > 0) begin
         m_ready = 1'b0;
         stall_ready--;
      end else if (rand_ready) begin
         m_ready = ($urandom_range(99) < 70);
      end else begin
         m_ready = 1'b1;
      end
      @(negedge clk);
      acc_s = s_valid & s_ready;
   endtask

   task automatic drain(input int limit);
      int  n;
      bit  empty;
      n = 0;
      empty = 1'b0;
      while (n < limit && !empty) begin
         applyStimulus();
         n++;
         empty = (s_valid == '0) && (mdl_owner < 0);
         for (int p = 0; p < NP; p++) if (drv_q[p].size() != 0) empty = 1'b0;
      end
      if (!empty) begin
         total++;
         bad++;
         $display("[TB] FAIL drain_timeout: got %0d cycles without draining, want fewer than %0d", n, limit);
      end
      repeat (2) applyStimulus();
   endtask

   task automatic checkOrder(input string tag);
      checkOutput({tag, "_order_len"}, 64'(out_order.size()), 64'(exp_order.size()));
      for (int i = 0; i < exp_order.size() && i < out_order.size(); i++) begin
         checkOutput({tag, "_order"}, 64'(out_order[i]), 64'(exp_order[i]));
      end
      out_order.delete();
      exp_order.delete();
   endtask

   // Compare process: every falling edge, DUT outputs against the model, then advance the model.
   always @(negedge clk) begin : cmp
      int            o;
      bit            found;
      int            c;
      beat_t         bt;
      logic [NP-1:0] e_ready;
      logic [DW-1:0] e_data;
      logic [IW-1:0] e_idx;
      logic          e_valid, e_last, e_abort, e_busy;
      logic [PW-1:0] e_port;
      o = mdl_owner;
      e_ready = '0; e_data = '0; e_idx = '0; e_port = '0;
      e_valid = 1'b0; e_last = 1'b0; e_abort = 1'b0; e_busy = 1'b0;
      if (!rst_n) begin
         mdl_owner = -1;
         mdl_rr    = 0;
         mdl_idle  = 0;
         mdl_abort = 1'b0;
         o = -1;
      end else if (o >= 0) begin
         e_busy = 1'b1;
         e_port = PW'(o);
         if (mdl_abort) begin
            e_valid = 1'b1;
            e_last  = 1'b1;
            e_abort = 1'b1;
         end else begin
            e_valid    = s_valid[o];
            e_data     = s_tdata[o*DW +: DW];
            e_idx      = s_idx[o*IW +: IW];
            e_last     = s_last[o];
            e_ready[o] = m_ready;
         end
      end
      checkOutput("m_valid", 64'(m_valid), 64'(e_valid));
      checkOutput("m_last",  64'(m_last),  64'(e_last));
      checkOutput("m_abort", 64'(m_abort), 64'(e_abort));
      checkOutput("busy",    64'(busy),    64'(e_busy));
      checkOutput("m_port",  64'(m_port),  64'(e_port));
      checkOutput("m_tdata", m_tdata,      e_data);
      checkOutput("m_idx",   64'(m_idx),   64'(e_idx));
      checkOutput("s_ready", 64'(s_ready), 64'(e_ready));
      if (rst_n && o >= 0) begin
         if (e_valid && m_ready) begin
            if (e_abort) begin
               out_order.push_back(o);
            end else if (exp_q[o].size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL sb_extra: got a beat from port %0d, want none pending", o);
            end else begin
               bt = exp_q[o].pop_front();
               checkOutput("sb_data", m_tdata, bt.data);
               checkOutput("sb_idx",  64'(m_idx),  64'(bt.idx));
               checkOutput("sb_last", 64'(m_last), 64'(bt.last));
               if (bt.last) out_order.push_back(o);
            end
         end
         if (mdl_abort) begin
            if (m_ready) begin
               mdl_rr    = (o + 1) % NP;
               mdl_owner = -1;
               mdl_abort = 1'b0;
            end
         end else if (s_valid[o]) begin
            mdl_idle = 0;
            if (m_ready && s_last[o]) begin
               mdl_rr    = (o + 1) % NP;
               mdl_owner = -1;
            end
         end else begin
`ifdef INGRESS_ARB_TIMEOUT_EN
            mdl_idle++;
            if (mdl_idle == TO) mdl_abort = 1'b1;
`endif
         end
      end else if (rst_n) begin
         found = 1'b0;
         for (int k = 0; k < NP; k++) begin
            c = (mdl_rr + k) % NP;
            if (!found && s_valid[c]) begin
               found     = 1'b1;
               mdl_owner = c;
               mdl_idle  = 0;
            end
         end
      end
   end

   initial begin : stim
      beat_t bt;
      bit    got;
      int    idle_seen;
      total = 0; bad = 0;
      s_valid = '0; s_last = '0; s_tdata = '0; s_idx = '0;
      m_ready = 1'b1; gap_pct = 0; rand_ready = 1'b0; stall_ready = 0; acc_s = '0;
      mdl_owner = -1; mdl_rr = 0; mdl_idle = 0; mdl_abort = 1'b0;
      for (int p = 0; p < NP; p++) begin
         stall_at[p] = -1;
         sent_in_pkt[p] = 0;
      end

      repeat (3) applyStimulus();
      #1 rst_n = 1'b1;
      repeat (2) applyStimulus();
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
      checkOutput("rst_s_ready", 64'(s_ready), 64'd0);

      // Single-beat packet on port 2: bubble cycle, then the beat, then idle again.
      bt.data = 64'h0800_4500_1234_5678; bt.idx = 4'd8; bt.last = 1'b1;
      pushBeat(2, bt);
      applyStimulus();
      checkOutput("single_bubble", 64'(m_valid), 64'd0);
      applyStimulus();
      checkOutput("single_valid", 64'(m_valid), 64'd1);
      checkOutput("single_port",  64'(m_port),  64'd2);
      checkOutput("single_data",  m_tdata,      64'h0800_4500_1234_5678);
      checkOutput("single_idx",   64'(m_idx),   64'd8);
      checkOutput("single_last",  64'(m_last),  64'd1);
      applyStimulus();
      checkOutput("single_done", 64'(busy), 64'd0);
      exp_order.push_back(2);

      // rr now 3: port 3 beats port 0; then rr=1 so port 1 beats port 0.
      pushPacket(0, 1, 64'hA000); pushPacket(3, 1, 64'hA300);
      drain(50);
      exp_order.push_back(3); exp_order.push_back(0);
      pushPacket(0, 3, 64'hB000); pushPacket(1, 3, 64'hB100);
      drain(50);
      exp_order.push_back(1); exp_order.push_back(0);

      // All ports saturated with 2-beat packets; rr starts at 1.
      for (int r = 0; r < 4; r++)
         for (int p = 0; p < NP; p++) pushPacket(p, 2, 64'hC000 + 64'(r*16 + p*256));
      drain(200);
      for (int r = 0; r < 4; r++) begin
         exp_order.push_back(1); exp_order.push_back(2);
         exp_order.push_back(3); exp_order.push_back(0);
      end

      // Backpressure: hold m_ready low for 5 cycles right after the first beat of port 2.
      pushPacket(2, 4, 64'hBB00);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         applyStimulus();
         if (m_valid && s_ready[2]) got = 1'b1;
      end
      checkOutput("bp_first_beat_seen", 64'(got), 64'd1);
      stall_ready = 5;
      for (int i = 0; i < 5; i++) begin
         applyStimulus();
         checkOutput("bp_hold_valid", 64'(m_valid), 64'd1);
         checkOutput("bp_hold_ready", 64'(s_ready), 64'd0);
         checkOutput("bp_hold_data",  m_tdata,      64'hBB01);
      end
      drain(50);
      exp_order.push_back(2);
      checkOrder("directed");

`ifdef INGRESS_ARB_TIMEOUT_EN
      // Port 1 stops after 2 of 4 beats; abort terminator after TO idle cycles, rr then 2.
      stall_at[1] = 2;
      pushPacket(1, 4, 64'hCC00);
      got = 1'b0;
      idle_seen = 0;
      for (int i = 0; i < 60 && !got; i++) begin
         applyStimulus();
         if (m_abort) got = 1'b1;
         else if (busy && !m_valid) idle_seen++;
      end
      checkOutput("to_abort_seen", 64'(got), 64'd1);
      checkOutput("to_idle_cycles", 64'(idle_seen), 64'd8);
      checkOutput("to_last", 64'(m_last), 64'd1);
      checkOutput("to_idx",  64'(m_idx),  64'd0);
      checkOutput("to_data", m_tdata,     64'd0);
      checkOutput("to_port", 64'(m_port), 64'd1);
      exp_order.push_back(1);
      applyStimulus();
      pushPacket(0, 1, 64'hDD00); pushPacket(2, 1, 64'hDD20);
      repeat (8) applyStimulus();
      stall_at[1] = -1;
      drain(50);
      exp_order.push_back(2); exp_order.push_back(0); exp_order.push_back(1);
      checkOrder("timeout");
`endif

      // Reset while beat 2 of 5 from port 1 is on the output.
      pushPacket(1, 5, 64'hEE00);
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         applyStimulus();
         if (m_valid && m_tdata == 64'hEE01) got = 1'b1;
      end
      checkOutput("rst_mid_beat2_seen", 64'(got), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_valid", 64'(m_valid), 64'd0);
      checkOutput("rst_mid_last",  64'(m_last),  64'd0);
      checkOutput("rst_mid_busy",  64'(busy),    64'd0);
      checkOutput("rst_mid_ready", 64'(s_ready), 64'd0);
      checkOutput("rst_mid_port",  64'(m_port),  64'd0);
      checkOutput("rst_mid_data",  m_tdata,      64'd0);
      for (int p = 0; p < NP; p++) begin
         drv_q[p].delete();
         exp_q[p].delete();
         sent_in_pkt[p] = 0;
      end
      s_valid = '0;
      acc_s = '0;
      out_order.delete();
      repeat (2) applyStimulus();
      #1 rst_n = 1'b1;
      pushPacket(3, 1, 64'hF300);
      applyStimulus();
      applyStimulus();
      checkOutput("post_rst_valid", 64'(m_valid), 64'd1);
      checkOutput("post_rst_port",  64'(m_port),  64'd3);
      drain(50);
      exp_order.push_back(3);
      checkOrder("reset");

      // Randomized traffic: gaps between beats, random downstream stalls.
      gap_pct = 30;
      rand_ready = 1'b1;
      for (int k = 0; k < 6; k++)
         for (int p = 0; p < NP; p++)
            pushPacket(p, 1 + int'($urandom_range(4)), {$urandom, $urandom});
      drain(4000);
      rand_ready = 1'b0;
      gap_pct = 0;
      repeat (2) applyStimulus();
      for (int p = 0; p < NP; p++) checkOutput("sb_leftover", 64'(exp_q[p].size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ingress_pkt_arbiter.md
# ingress_pkt_arbiter

Packet-granular round-robin arbiter that shares one parser pipeline (Ethernet → IPv4 → L4) between NUM_PORTS ingress byte-lane streams. It locks the grant for a whole packet, so beats from different sources never interleave, and holds the other ports with backpressure. It sits directly upstream of the Ethernet parser. Its output carries the same tdata/idx/valid/last beat format the parser chain consumes, plus a source-port tag.

## Interface
- DATA_WIDTH, 64: beat width in bits; valid byte count is carried in idx.
- NUM_PORTS, 4: number of ingress requesters, 2..8.
- TIMEOUT_CYCLES, 256: idle-beat limit for a granted packet; used only with the timeout feature.
- Derived localparams: IDX_W = $clog2(DATA_WIDTH/8+1) and PORT_W = $clog2(NUM_PORTS).
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_tdata  in  NUM_PORTS*DATA_WIDTH  per-port beat data; port p uses slice [p*DATA_WIDTH +: DATA_WIDTH].
- s_idx  in  NUM_PORTS*IDX_W  per-port count of valid bytes, 0..DATA_WIDTH/8.
- s_valid  in  NUM_PORTS  per-port beat valid.
- s_last  in  NUM_PORTS  per-port last beat of packet.
- s_ready  out  NUM_PORTS  per-port beat accept.
- m_tdata  out  DATA_WIDTH  granted beat data.
- m_idx  out  IDX_W  granted beat byte count.
- m_valid  out  1  output beat valid.
- m_last  out  1  output last beat.
- m_ready  in  1  downstream accept.
- m_port  out  PORT_W  source port of the current packet.
- m_abort  out  1  current beat is a synthetic abort terminator.
- busy  out  1  a grant is held (state is not IDLE).

## Operation
- Beat transfer occurs on port p when s_valid[p] && s_ready[p]. Output transfer occurs when m_valid && m_ready.
- State IDLE:
  - All s_ready, m_valid, m_last, m_abort and busy are 0. m_tdata, m_idx and m_port are 0.
  - If any s_valid is set, grant the first requesting port found scanning upward from rr_ptr, wrapping modulo NUM_PORTS.
  - Register that port as grant and go to PASS.
- State PASS: combinational path from port grant to the output.
  - m_valid = s_valid[grant] and s_ready[grant] = m_ready.
  - m_tdata, m_idx and m_last are muxed from port grant.
  - m_port = grant and busy = 1. All other s_ready bits are 0.
  - On a transfer with s_last[grant] set: go to IDLE and set rr_ptr = (grant+1) mod NUM_PORTS.
- idx = 0 beats pass through unchanged and are not filtered.
- rr_ptr resets to 0. It advances only on packet completion or on abort.
- s_valid on a non-granted port has no effect until the next IDLE evaluation.
- A single-beat packet (s_last set on the first beat) completes PASS in one transfer.

## Timing
- Arbitration costs a 1-cycle bubble: the IDLE decision cycle transfers no data.
  - Minimum per-packet overhead is 1 cycle.
  - Back-to-back single-beat packets therefore sustain 50% throughput.
- In PASS the path is zero-latency combinational. Data, valid, last and ready are not registered.
- After reset deassertion, the earliest grant decision is the first clk edge with any s_valid set.
  - The first output beat can appear in the following cycle.
- Reset mid-packet: state returns to IDLE, rr_ptr becomes 0 and every output drops to 0 asynchronously.
  - The partial packet is not terminated. Downstream parsers must be reset from the same rst_n.

## Configuration
- Macro INGRESS_ARB_TIMEOUT_EN.
- When defined:
  - A counter in PASS counts consecutive cycles with s_valid[grant]=0. Any valid cycle clears it, and so does entering PASS.
  - Cycles with valid high but m_ready low are not counted.
  - When the count reaches TIMEOUT_CYCLES, go to state ABORT.
  - ABORT drives m_valid=1, m_last=1, m_abort=1, m_idx=0, m_tdata=0, m_port=grant and s_ready all 0.
  - When m_ready is seen in ABORT, go to IDLE and advance rr_ptr past grant.
  - Late beats from the aborted port are arbitrated as a new packet.
- When undefined:
  - There is no ABORT state and no counter, and TIMEOUT_CYCLES is ignored.
  - m_abort is tied to 0. A stalled granted port holds the grant indefinitely.

## Test plan
- Single-beat packet:
  - Stimulus: port 2 sends one beat with idx=8, tdata=64'h0800_4500_1234_5678 and last=1, with m_ready=1.
  - Required response: one beat out 1 cycle after valid, with the same data, m_port=2 and m_last=1. State returns to IDLE and rr_ptr=3.
- Simultaneous request:
  - Stimulus: ports 0 and 1 each send a 3-beat packet starting in the same cycle.
  - Required response: port 0's 3 beats, then a 1-cycle gap, then port 1's 3 beats, with no interleave. s_ready[1]=0 throughout port 0's packet.
- Round-robin fairness:
  - Stimulus: all 4 ports continuously present 2-beat packets for 16 packets.
  - Required response: m_port sequence 0,1,2,3 repeated 4 times.
- Backpressure:
  - Stimulus: m_ready is low for 5 cycles mid-packet.
  - Required response: the granted beat is held stable with m_valid=1, s_ready[grant]=0 and no beat lost or duplicated. Beat count and idx sum match the input.
- Timeout (macro defined, TIMEOUT_CYCLES=8):
  - Stimulus: port 1 stops after 2 of 4 beats.
  - Required response: after 8 idle cycles, one beat out with m_abort=1, m_last=1 and m_idx=0. State goes to IDLE and rr_ptr=2.
- Reset mid-packet:
  - Stimulus: assert rst_n=0 on beat 2 of 5.
  - Required response: all outputs drop to 0 immediately. After release, a new request on port 3 is granted first (no port 0 request present).
